gate_stimulus_driver: RTL and testbench

Sequential stimulus driver and response checker for two-input combinational gate blocks. On a start pulse it steps through the four input combinations. For each one it drives `o_a`/`o_b`, waits a programmable settle time, samples the gate output on `i_q`, and compares the captured truth table against an expected one. It is the initiator end of the `i_a`/`i_b` -> `o_q` gate interface. It sits beside the gate under test in self-checking hardware demos.

---
 rtl/gate_drv_pkg.sv | 15 +
 rtl/settle_counter.sv | 34 +++
 rtl/gate_stimulus_driver.sv | 143 ++++++++++++++
 tb/tb_gate_stimulus_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gate_drv_pkg.sv
// Shared types and sizes for the gate stimulus driver and its settle timer.
package gate_drv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int NUM_COMBOS = 4;
  localparam int IDX_W      = 2;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/settle_counter.sv
// Load/decrement down-counter that times how long each input combination is held.
module settle_counter
  import gate_drv_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/gate_stimulus_driver.sv
// Sweeps {a,b} through all four combinations, samples the gate under test and
// compares the captured truth table against EXPECTED.
//
//   state  | meaning
//   IDLE   | outputs parked at 0, waiting for i_start
//   SETTLE | combination idx driven, waiting SETTLE_CYCLES for the gate
//   SAMPLE | one cycle; i_q captured into result[idx] on its closing edge
//   DONE   | final compare registered; o_done pulses on the following cycle
module gate_stimulus_driver
  import gate_drv_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED      = 4'b1010
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_q,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_result,
  output logic [3:0] o_fail_vec,
  output logic       o_pass
);

  // The counter sits at zero during the last settle cycle, hence the minus one.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMBOS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             a_q, a_d, b_q, b_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]       result_q, result_d, fail_q, fail_d;
  logic             cnt_load, cnt_dec, cnt_zero;

  settle_counter u_settle_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (LOAD_VAL),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (i_abort) begin
      // Partial result is kept for debug; everything else parks.
      state_d = IDLE;
      idx_d   = '0;
      a_d     = 1'b0;
      b_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d  = SETTLE;
            idx_d    = '0;
            a_d      = 1'b0;
            b_d      = 1'b0;
            cnt_load = 1'b1;
            result_d = '0;
            fail_d   = '0;
            pass_d   = 1'b0;
          end
        end
        SETTLE: begin
          if (cnt_zero) state_d = SAMPLE;
          else          cnt_dec = 1'b1;
        end
        SAMPLE: begin
          result_d[idx_q] = i_q;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            a_d     = 1'b0;
            b_d     = 1'b0;
            fail_d  = result_d ^ EXPECTED;
            pass_d  = (fail_d == '0);
          end else begin
            state_d    = SETTLE;
            idx_d      = idx_q + 1'b1;
            {a_d, b_d} = idx_d;
            cnt_load   = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      fail_q   <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
    end
  end

  assign o_a        = a_q;
  assign o_b        = b_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_fail_vec = fail_q;
  assign o_pass     = pass_q;

endmodule

// File: tb/tb_gate_stimulus_driver.sv
// Self-checking bench: per-cycle timeline model for the default instance plus
// directed literal checks, and a second instance at minimum settle time.
module tb_gate_stimulus_driver;

  localparam int         P   = 3;        // S+1 for the main instance
  localparam logic [3:0] EXP = 4'b1010;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  int   mode = 0;                        // 0: q=b, 1: q=a|b, 2: q=a&b
  logic a, b, busy, done, pass, q;
  logic [3:0] res, fail_vec;

  logic start2 = 1'b0, abort2 = 1'b0;
  logic a2, b2, busy2, done2, pass2, q2;
  logic [3:0] res2, fail2;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  assign q  = (mode == 0) ? b : (mode == 1) ? (a | b) : (a & b);
  assign q2 = a2 & b2;

  gate_stimulus_driver dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_q(q),
    .o_a(a), .o_b(b), .o_busy(busy), .o_done(done),
    .o_result(res), .o_fail_vec(fail_vec), .o_pass(pass)
  );

  gate_stimulus_driver #(.SETTLE_CYCLES(1), .EXPECTED(4'b1000)) dut_min (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_abort(abort2), .i_q(q2),
    .o_a(a2), .o_b(b2), .o_busy(busy2), .o_done(done2),
    .o_result(res2), .o_fail_vec(fail2), .o_pass(pass2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] truth(input int m);
    logic [3:0] tt;
    for (int j = 0; j < 4; j++) begin
      logic aa, bb;
      aa = (j >= 2);
      bb = (j % 2 == 1);
      tt[j] = (m == 0) ? bb : (m == 1) ? (aa | bb) : (aa & bb);
    end
    return tt;
  endfunction

  // Bits captured after t cycles into a sweep: one per elapsed (S+1) window.
  function automatic logic [3:0] partial(input int t, input logic [3:0] tt);
    int n;
    n = t / P;
    if (n > 4) n = 4;
    return tt & 4'((1 << n) - 1);
  endfunction

  // Model: m_t = cycles since the accepted start edge, -1 when idle.
  int         m_t    = -1;
  logic [3:0] m_res  = 4'h0, m_fail = 4'h0;
  logic       m_pass = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = -1; m_res = 4'h0; m_fail = 4'h0; m_pass = 1'b0;
    end else begin
      if (m_t >= 0) begin
        m_res = partial(m_t, truth(mode));
        if (m_t >= 4*P) begin
          m_fail = m_res ^ EXP;
          m_pass = (m_fail == 4'h0);
        end
      end
      if (abort) m_t = -1;
      else if ((m_t < 0 || m_t == 4*P+1) && start) begin
        m_t = 0; m_res = 4'h0; m_fail = 4'h0; m_pass = 1'b0;
      end
      else if (m_t == 4*P+1) m_t = -1;
      else if (m_t >= 0) m_t++;
    end
  end

  function automatic logic [12:0] expect_now();
    logic [3:0] tt;
    tt = truth(mode);
    if (m_t < 0) return {2'b00, 1'b0, 1'b0, m_res, m_fail, m_pass};
    if (m_t < 4*P) return {2'(m_t / P), 1'b1, 1'b0, partial(m_t, tt), 4'h0, 1'b0};
    return {2'b00, 1'b0, (m_t == 4*P+1), tt, tt ^ EXP, ((tt ^ EXP) == 4'h0)};
  endfunction

  always @(negedge clk)
    check("cycle", {19'b0, a, b, busy, done, res, fail_vec, pass}, {19'b0, expect_now()});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input int restart_at, input int abort_at,
                       output int done_at, output int done_cnt, output logic [7:0] ab_seen);
    done_at = -1; done_cnt = 0; ab_seen = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 36; t++) begin
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
      if (t % P == 0 && t < 4*P) ab_seen[2*(t/P) +: 2] = {a, b};
      start = (t == restart_at);
      abort = (t == abort_at);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  int         da, dc;
  logic [7:0] ab;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_main", {19'b0, a, b, busy, done, res, fail_vec, pass}, 32'h0);
    check("reset_min", {19'b0, a2, b2, busy2, done2, res2, fail2, pass2}, 32'h0);
    rst_n = 1'b1;
    tick();

    mode = 0;
    sweep(-1, -1, da, dc, ab);
    check("buf_done_at", da, 13);
    check("buf_done_cnt", dc, 1);
    check("buf_ab_steps", ab, 8'hE4);
    check("buf_result", res, 4'b1010);
    check("buf_fail_vec", fail_vec, 4'h0);
    check("buf_pass", pass, 1);

    mode = 1;
    sweep(-1, -1, da, dc, ab);
    check("or_done_at", da, 13);
    check("or_result", res, 4'b1110);
    check("or_fail_vec", fail_vec, 4'b0100);
    check("or_pass", pass, 0);

    mode = 0;
    sweep(-1, 7, da, dc, ab);
    check("abort_done_cnt", dc, 0);
    check("abort_result", res, 4'b0010);
    check("abort_pass", pass, 0);
    check("abort_ab_busy", {a, b, busy}, 3'b000);

    sweep(5, -1, da, dc, ab);
    check("restart_done_at", da, 13);
    check("restart_done_cnt", dc, 1);
    check("restart_pass", pass, 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 7; t++) tick();
    check("pre_reset_result", res, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", {19'b0, a, b, busy, done, res, fail_vec, pass}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    sweep(-1, -1, da, dc, ab);
    check("post_reset_done_at", da, 13);
    check("post_reset_pass", pass, 1);
    check("post_reset_result", res, 4'b1010);

    da = -1; dc = 0; ab = 8'h00;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done2) begin
        dc++;
        if (da < 0) da = t;
      end
      if (t % 2 == 0 && t < 8) ab[2*(t/2) +: 2] = {a2, b2};
      tick();
    end
    check("min_done_at", da, 9);
    check("min_done_cnt", dc, 1);
    check("min_ab_steps", ab, 8'hE4);
    check("min_result", res2, 4'b1000);
    check("min_pass", pass2, 1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
